// File: rtl/trig_seq_monitor.sv
// trig_seq_monitor: pipelined masked-pattern trigger detector with consecutive or
// cumulative match counting and a sticky alarm that snapshots the triggering vector.
module trig_seq_monitor #(
    parameter int WIDTH  = 6,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 4,
    parameter int THRESH = 5,
    parameter int MODE   = 0
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] pat,
    input  logic [WIDTH-1:0] mask,
    input  logic             en,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] cnt,
    output logic             alarm,
    output logic [WIDTH-1:0] snap
);
    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0]            enp;
    logic [WIDTH-1:0]            pipe_out;
    logic                        en_out;
    logic                        hit;
    logic                        set;
    logic [CNT_W-1:0]            cnt_inc;
    logic [CNT_W-1:0]            cnt_nxt;

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            stage <= '0;
            enp   <= '0;
        end else begin
            stage[0] <= din;
            enp[0]   <= en;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
                enp[i]   <= enp[i-1];
            end
        end
    end

    assign pipe_out = stage[DEPTH-1];
    assign en_out   = enp[DEPTH-1];

    // pat/mask are applied live to the delayed vector, never realigned
    always_comb begin
        hit     = en_out && (((pipe_out ^ pat) & mask) == '0);
        cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
        cnt_nxt = hit ? cnt_inc : ((MODE == 1) ? cnt : '0);
        set     = !alarm && hit && (cnt == CNT_W'(THRESH - 1));
    end

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            match <= 1'b0;
            cnt   <= '0;
            alarm <= 1'b0;
            snap  <= '0;
        end else if (clr) begin
            match <= 1'b0;
            cnt   <= '0;
            alarm <= 1'b0;
            snap  <= '0;
        end else begin
            match <= hit;
            cnt   <= cnt_nxt;
            if (set) begin
                alarm <= 1'b1;
                snap  <= pipe_out;
            end
        end
    end
endmodule

// File: tb/tb_trig_seq_monitor.sv
// tb_trig_seq_monitor: directed checks of a consecutive-mode and a cumulative-mode
// instance driven by identical stimulus.
module tb_trig_seq_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] din = 6'h3F;
    logic [5:0] pat = 6'b101101;
    logic [5:0] mask = 6'h3F;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       match0, match1, alarm0, alarm1;
    logic [3:0] cnt0, cnt1;
    logic [5:0] snap0, snap1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    trig_seq_monitor #(.MODE(0)) dut0 (
        .I1470(clk), .I1477(rst_n), .din(din), .pat(pat), .mask(mask), .en(en), .clr(clr),
        .match(match0), .cnt(cnt0), .alarm(alarm0), .snap(snap0)
    );
    trig_seq_monitor #(.MODE(1)) dut1 (
        .I1470(clk), .I1477(rst_n), .din(din), .pat(pat), .mask(mask), .en(en), .clr(clr),
        .match(match1), .cnt(cnt1), .alarm(alarm1), .snap(snap1)
    );

    typedef struct {
        logic [5:0] din;
        logic       en;
        logic       clr;
        logic       m;
        int         c0;
        logic       a0;
        int         c1;
        logic       a1;
        logic [5:0] s0;
        logic [5:0] s1;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic m, input int c0, input logic a0,
                           input int c1, input logic a1, input logic [5:0] s0, input logic [5:0] s1);
        chk({tag, ".match0"}, 32'(match0), 32'(m));
        chk({tag, ".match1"}, 32'(match1), 32'(m));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(c0));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(c1));
        chk({tag, ".alarm0"}, 32'(alarm0), 32'(a0));
        chk({tag, ".alarm1"}, 32'(alarm1), 32'(a1));
        chk({tag, ".snap0"}, 32'(snap0), 32'(s0));
        chk({tag, ".snap1"}, 32'(snap1), 32'(s1));
    endtask

    initial begin
        // din, en, clr | match, cnt0, alarm0, cnt1, alarm1, snap0, snap1 after the edge
        tbl[0]  = '{6'h2D, 1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00};
        tbl[1]  = '{6'h2D, 1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00};
        tbl[2]  = '{6'h2D, 1, 0, 1, 1, 0, 1, 0, 6'h00, 6'h00};
        tbl[3]  = '{6'h2D, 1, 0, 1, 2, 0, 2, 0, 6'h00, 6'h00};
        tbl[4]  = '{6'h2C, 1, 0, 1, 3, 0, 3, 0, 6'h00, 6'h00};
        tbl[5]  = '{6'h2D, 1, 0, 1, 4, 0, 4, 0, 6'h00, 6'h00};
        tbl[6]  = '{6'h2D, 1, 0, 0, 0, 0, 4, 0, 6'h00, 6'h00};
        tbl[7]  = '{6'h2D, 1, 0, 1, 1, 0, 5, 1, 6'h00, 6'h2D};
        tbl[8]  = '{6'h2D, 1, 0, 1, 2, 0, 6, 1, 6'h00, 6'h2D};
        tbl[9]  = '{6'h00, 0, 0, 1, 3, 0, 7, 1, 6'h00, 6'h2D};
        tbl[10] = '{6'h00, 0, 0, 1, 4, 0, 8, 1, 6'h00, 6'h2D};
        tbl[11] = '{6'h00, 0, 0, 0, 0, 0, 8, 1, 6'h00, 6'h2D};
        tbl[12] = '{6'h00, 0, 0, 0, 0, 0, 8, 1, 6'h00, 6'h2D};
        tbl[13] = '{6'h00, 0, 1, 0, 0, 0, 0, 0, 6'h00, 6'h00};
        tbl[14] = '{6'h2D, 1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00};
        tbl[15] = '{6'h2D, 1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00};
        tbl[16] = '{6'h2D, 1, 0, 1, 1, 0, 1, 0, 6'h00, 6'h00};
        tbl[17] = '{6'h2D, 1, 0, 1, 2, 0, 2, 0, 6'h00, 6'h00};
        tbl[18] = '{6'h2D, 1, 0, 1, 3, 0, 3, 0, 6'h00, 6'h00};
        tbl[19] = '{6'h00, 0, 0, 1, 4, 0, 4, 0, 6'h00, 6'h00};
        tbl[20] = '{6'h00, 0, 0, 1, 5, 1, 5, 1, 6'h2D, 6'h2D};
        tbl[21] = '{6'h00, 0, 0, 0, 0, 1, 5, 1, 6'h2D, 6'h2D};
        tbl[22] = '{6'h00, 0, 0, 0, 0, 1, 5, 1, 6'h2D, 6'h2D};

        #1;
        chk_all("rst_t0", 0, 0, 0, 0, 0, 6'h00, 6'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("rst_hold%0d", i), 0, 0, 0, 0, 0, 6'h00, 6'h00);
        end
        rst_n = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 6'h00, 6'h00);
        end

        for (int r = 0; r < 23; r++) begin
            din = tbl[r].din;
            en  = tbl[r].en;
            clr = tbl[r].clr;
            tick();
            chk_all($sformatf("vec%0d", r), tbl[r].m, tbl[r].c0, tbl[r].a0,
                    tbl[r].c1, tbl[r].a1, tbl[r].s0, tbl[r].s1);
        end

        en = 1'b0;
        clr = 1'b1;
        tick();
        chk_all("sat_clr", 0, 0, 0, 0, 0, 6'h00, 6'h00);
        clr = 1'b0;
        mask = 6'b000011;
        pat = 6'b000001;
        for (int i = 0; i < 22; i++) begin
            int         c;
            logic       a;
            din = (i < 6) ? 6'b111101 : 6'b111001;
            en = 1'b1;
            tick();
            c = (i < 2) ? 0 : ((i - 1 > 15) ? 15 : i - 1);
            a = (c >= 5);
            chk_all($sformatf("sat%0d", i), i >= 2, c, a, c, a,
                    a ? 6'b111101 : 6'h00, a ? 6'b111101 : 6'h00);
        end

        en = 1'b0;
        clr = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_all("cs_clr", 0, 0, 0, 0, 0, 6'h00, 6'h00);
        pat = 6'b101101;
        mask = 6'h3F;
        for (int j = 0; j < 12; j++) begin
            int c;
            din = 6'b101101;
            en = 1'b1;
            clr = (j == 6);
            tick();
            c = (j < 2) ? 0 : (j < 6) ? j - 1 : (j == 6) ? 0 : j - 6;
            chk_all($sformatf("cs%0d", j), (j >= 2) && (j != 6), c, j >= 11, c, j >= 11,
                    (j >= 11) ? 6'h2D : 6'h00, (j >= 11) ? 6'h2D : 6'h00);
        end
        clr = 1'b0;

        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 6'h00, 6'h00);
        tick();
        chk_all("async_hold", 0, 0, 0, 0, 0, 6'h00, 6'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
